// File: rtl/cpu_mem_pkg.sv
// Shared constants and encodings for the CPU memory responder.
//   CM_*           : default widths and depth for the instruction and data arrays
//   state_t        : responder FSM states
//   SEL_INSTR/DATA : host_sel encoding
package cpu_mem_pkg;

  localparam int CM_DATA_WIDTH = 10;
  localparam int CM_WORD_WIDTH = 8;
  localparam int CM_MEM_DEPTH  = 8;
  localparam int CM_ADDR_WIDTH = 3;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_READY    = 2'd1,
    ST_HOST_RSP = 2'd2
  } state_t;

  localparam logic SEL_INSTR = 1'b0;
  localparam logic SEL_DATA  = 1'b1;

endpackage

// File: rtl/cpu_mem_bank.sv
// Single memory array with one write port, one registered CPU read port and
// an unregistered peek port used by the host path.
//   clk, rstn        : clock, synchronous active-low reset (clears rdata only)
//   we/waddr/wdata   : write port, commits at the clock edge
//   re/raddr/rdata   : registered read; rdata holds while re is low
//   peek_addr/data   : combinational read, captured by the top on a host accept
// Addresses at or beyond DEPTH read as zero and writes to them are dropped.
module cpu_mem_bank
  import cpu_mem_pkg::*;
#(
  parameter int WIDTH = CM_WORD_WIDTH,
  parameter int DEPTH = CM_MEM_DEPTH,
  parameter int AW    = CM_ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [WIDTH-1:0] rdata,
  input  logic [AW-1:0] peek_addr,
  output logic [WIDTH-1:0] peek_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  // Storage has no reset; the top level clears it entry by entry after reset.
  always_ff @(posedge clk) begin
    if (we && in_range(waddr)) mem[waddr] <= wdata;
  end

  // Non-blocking update gives read-before-write on a same-address collision.
  always_ff @(posedge clk) begin
    if (!rstn)   rdata <= '0;
    else if (re) rdata <= in_range(raddr) ? mem[raddr] : '0;
  end

  assign peek_data = in_range(peek_addr) ? mem[peek_addr] : '0;

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the CPU instruction and data interfaces, with a
// host load/readback port.
//   clk, rstn                    : clock, synchronous active-low reset
//   instr_mem_*                  : CPU instruction read (registered, held)
//   data_mem_*                   : CPU data read/write (registered read, held)
//   cpu_busy                     : CPU running; blocks host accesses
//   host_req_valid/ready         : host request handshake
//   host_sel/wr/addr/wdata       : host request fields
//   host_rsp_valid/data          : one-cycle host response
//   init_done                    : arrays cleared, requests being served
//   dbg_state                    : current FSM state (state_t encoding)
//
// Handshake: a host request transfers on a clock edge where host_req_valid and
// host_req_ready are both high. ready is only high in READY with no CPU
// activity, so at most one request is outstanding; its response is presented
// for exactly the following cycle with host_rsp_valid high.
module cpu_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int DATA_WIDTH = CM_DATA_WIDTH,
  parameter int WORD_WIDTH = CM_WORD_WIDTH,
  parameter int MEM_DEPTH  = CM_MEM_DEPTH,
  parameter int ADDR_WIDTH = CM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_WIDTH-1:0] instr_mem_addr,
  input  logic                  instr_mem_rd_en,
  output logic [DATA_WIDTH-1:0] instr_mem_data_out,
  input  logic [ADDR_WIDTH-1:0] data_mem_addr,
  input  logic                  data_mem_rd_en,
  input  logic                  data_mem_wr_en,
  input  logic [WORD_WIDTH-1:0] data_mem_data_in,
  output logic [WORD_WIDTH-1:0] data_mem_data_out,
  input  logic                  cpu_busy,
  input  logic                  host_req_valid,
  output logic                  host_req_ready,
  input  logic                  host_sel,
  input  logic                  host_wr,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_rsp_valid,
  output logic [DATA_WIDTH-1:0] host_rsp_data,
  output logic                  init_done,
  output logic [1:0]            dbg_state
);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_idx, clr_nxt;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_capture;
  logic                  in_init, host_acc;

  logic                  i_we, d_we;
  logic [ADDR_WIDTH-1:0] i_waddr, d_waddr;
  logic [DATA_WIDTH-1:0] i_wdata, i_peek;
  logic [WORD_WIDTH-1:0] d_wdata, d_peek;

  assign in_init        = (state == ST_INIT);
  assign host_req_ready = (state == ST_READY) & ~cpu_busy & ~instr_mem_rd_en
                          & ~data_mem_rd_en & ~data_mem_wr_en;
  assign host_acc       = host_req_valid & host_req_ready;
  assign host_rsp_valid = (state == ST_HOST_RSP);
  assign host_rsp_data  = host_rsp_valid ? rsp_data_q : '0;
  assign init_done      = ~in_init;
  assign dbg_state      = state;

  // Write-port mux: clear sequence, then host, then CPU. host_acc implies no
  // CPU strobe, so host and CPU never compete for a port.
  always_comb begin
    i_we    = 1'b0;
    i_waddr = host_addr;
    i_wdata = host_wdata;
    d_we    = 1'b0;
    d_waddr = data_mem_addr;
    d_wdata = data_mem_data_in;
    if (in_init) begin
      i_we    = 1'b1;
      i_waddr = clr_idx;
      i_wdata = '0;
      d_we    = 1'b1;
      d_waddr = clr_idx;
      d_wdata = '0;
    end else if (host_acc) begin
      if (host_wr) begin
        if (host_sel == SEL_DATA) begin
          d_we    = 1'b1;
          d_waddr = host_addr;
          d_wdata = host_wdata[WORD_WIDTH-1:0];
        end else begin
          i_we = 1'b1;
        end
      end
    end else begin
      d_we = data_mem_wr_en;
    end
    // Nothing commits on a reset edge; the clear sequence restarts after it.
    if (!rstn) begin
      i_we = 1'b0;
      d_we = 1'b0;
    end
  end

  // Response payload: write echoes the stored value, read returns the array.
  always_comb begin
    if (host_wr) begin
      rsp_capture = (host_sel == SEL_DATA) ? DATA_WIDTH'(host_wdata[WORD_WIDTH-1:0])
                                           : host_wdata;
    end else begin
      rsp_capture = (host_sel == SEL_DATA) ? DATA_WIDTH'(d_peek) : i_peek;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= ST_INIT;
      clr_idx    <= '0;
      rsp_data_q <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_nxt;
      if (host_acc) rsp_data_q <= rsp_capture;
    end
  end

  always_comb begin
    state_nxt = state;
    clr_nxt   = clr_idx;
    case (state)
      ST_INIT: begin
        clr_nxt = clr_idx + ADDR_WIDTH'(1);
        if (clr_idx == ADDR_WIDTH'(MEM_DEPTH - 1)) state_nxt = ST_READY;
      end
      ST_READY: begin
        if (host_acc) state_nxt = ST_HOST_RSP;
      end
      ST_HOST_RSP: begin
        state_nxt = ST_READY;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  cpu_mem_bank #(
    .WIDTH(DATA_WIDTH), .DEPTH(MEM_DEPTH), .AW(ADDR_WIDTH)
  ) u_instr_bank (
    .clk      (clk),
    .rstn     (rstn),
    .we       (i_we),
    .waddr    (i_waddr),
    .wdata    (i_wdata),
    .re       (instr_mem_rd_en & ~in_init),
    .raddr    (instr_mem_addr),
    .rdata    (instr_mem_data_out),
    .peek_addr(host_addr),
    .peek_data(i_peek)
  );

  cpu_mem_bank #(
    .WIDTH(WORD_WIDTH), .DEPTH(MEM_DEPTH), .AW(ADDR_WIDTH)
  ) u_data_bank (
    .clk      (clk),
    .rstn     (rstn),
    .we       (d_we),
    .waddr    (d_waddr),
    .wdata    (d_wdata),
    .re       (data_mem_rd_en & ~in_init),
    .raddr    (data_mem_addr),
    .rdata    (data_mem_data_out),
    .peek_addr(host_addr),
    .peek_data(d_peek)
  );

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: directed steps followed by a
// randomized mix of host and CPU accesses, checked against array models.
module tb_cpu_mem_responder;

  localparam int DW = 10;
  localparam int WW = 8;
  localparam int AW = 3;
  localparam int DEPTH = 8;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rstn;
  logic [AW-1:0] instr_mem_addr;
  logic          instr_mem_rd_en;
  logic [DW-1:0] instr_mem_data_out;
  logic [AW-1:0] data_mem_addr;
  logic          data_mem_rd_en;
  logic          data_mem_wr_en;
  logic [WW-1:0] data_mem_data_in;
  logic [WW-1:0] data_mem_data_out;
  logic          cpu_busy;
  logic          host_req_valid;
  logic          host_req_ready;
  logic          host_sel;
  logic          host_wr;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_rsp_valid;
  logic [DW-1:0] host_rsp_data;
  logic          init_done;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  cpu_mem_responder dut (
    .clk               (clk),
    .rstn              (rstn),
    .instr_mem_addr    (instr_mem_addr),
    .instr_mem_rd_en   (instr_mem_rd_en),
    .instr_mem_data_out(instr_mem_data_out),
    .data_mem_addr     (data_mem_addr),
    .data_mem_rd_en    (data_mem_rd_en),
    .data_mem_wr_en    (data_mem_wr_en),
    .data_mem_data_in  (data_mem_data_in),
    .data_mem_data_out (data_mem_data_out),
    .cpu_busy          (cpu_busy),
    .host_req_valid    (host_req_valid),
    .host_req_ready    (host_req_ready),
    .host_sel          (host_sel),
    .host_wr           (host_wr),
    .host_addr         (host_addr),
    .host_wdata        (host_wdata),
    .host_rsp_valid    (host_rsp_valid),
    .host_rsp_data     (host_rsp_data),
    .init_done         (init_done),
    .dbg_state         (dbg_state)
  );

  // ---------------- reference model / scoreboard ----------------
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] im_m [DEPTH];
  logic [WW-1:0] dm_m [DEPTH];
  logic [DW-1:0] exp_iout;
  logic [WW-1:0] exp_dout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      im_m[i] = '0;
      dm_m[i] = '0;
    end
    exp_iout = '0;
    exp_dout = '0;
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_iout"}, instr_mem_data_out, exp_iout);
    check({tag, "_dout"}, data_mem_data_out, exp_dout);
  endtask

  task automatic cpu_iread(input logic [AW-1:0] a);
    instr_mem_addr  = a;
    instr_mem_rd_en = 1'b1;
    #1;
    check("iread_blocks_host", host_req_ready, 0);
    step();
    instr_mem_rd_en = 1'b0;
    exp_iout = im_m[a];
    check_outs("iread");
  endtask

  task automatic cpu_data(input logic rd, input logic wr, input logic [AW-1:0] a,
                          input logic [WW-1:0] wd);
    data_mem_addr    = a;
    data_mem_rd_en   = rd;
    data_mem_wr_en   = wr;
    data_mem_data_in = wd;
    #1;
    check("dacc_blocks_host", host_req_ready, 0);
    step();
    data_mem_rd_en = 1'b0;
    data_mem_wr_en = 1'b0;
    if (rd) exp_dout = dm_m[a];
    if (wr) dm_m[a] = wd;
    check_outs("dacc");
  endtask

  task automatic host_xfer(input logic sel, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic busy_after);
    int n;
    n = 0;
    host_req_valid = 1'b1;
    host_sel       = sel;
    host_wr        = wr;
    host_addr      = a;
    host_wdata     = wd;
    #1;
    while (!host_req_ready && n < 16) begin
      step();
      n++;
    end
    check("host_accept", host_req_ready, 1);
    if (wr) begin
      if (sel) begin
        dm_m[a] = wd[WW-1:0];
        exp_q.push_back({2'b00, wd[WW-1:0]});
      end else begin
        im_m[a] = wd;
        exp_q.push_back(wd);
      end
    end else begin
      exp_q.push_back(sel ? {2'b00, dm_m[a]} : im_m[a]);
    end
    step();
    host_req_valid = 1'b0;
    cpu_busy       = busy_after;
    check("rsp_valid", host_rsp_valid, 1);
    check("rsp_ready_low", host_req_ready, 0);
    check("rsp_data", host_rsp_data, exp_q.pop_front());
    step();
    check("rsp_single", host_rsp_valid, 0);
    check("rsp_data_idle", host_rsp_data, 0);
    cpu_busy = 1'b0;
  endtask

  task automatic wait_init(input string tag, output int n);
    n = 0;
    while (!init_done && n < 20) begin
      step();
      n++;
    end
    check(tag, n, 8);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int            n;
    int            op;
    logic [AW-1:0] a;

    rstn = 1'b0;
    instr_mem_addr = '0; instr_mem_rd_en = 1'b0;
    data_mem_addr = '0; data_mem_rd_en = 1'b0; data_mem_wr_en = 1'b0;
    data_mem_data_in = '0; cpu_busy = 1'b0;
    host_req_valid = 1'b0; host_sel = 1'b0; host_wr = 1'b0;
    host_addr = '0; host_wdata = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_iout", instr_mem_data_out, 0);
    check("rst_dout", data_mem_data_out, 0);
    check("rst_rsp_valid", host_rsp_valid, 0);
    check("rst_rsp_data", host_rsp_data, 0);
    check("rst_ready", host_req_ready, 0);
    check("rst_init_done", init_done, 0);

    // Init with CPU strobes active: writes ignored, read data stays 0.
    rstn = 1'b1;
    data_mem_rd_en = 1'b1; data_mem_wr_en = 1'b1;
    data_mem_addr = 3'd0; data_mem_data_in = 8'hFF;
    n = 0;
    while (!init_done && n < 20) begin
      step();
      n++;
      if (n == 4) begin
        check("init_dout_zero", data_mem_data_out, 0);
        data_mem_rd_en = 1'b0; data_mem_wr_en = 1'b0;
        #1;
        check("init_ready_low", host_req_ready, 0);
        data_mem_rd_en = 1'b1; data_mem_wr_en = 1'b1;
      end
    end
    check("init_cycles", n, 8);
    data_mem_rd_en = 1'b0; data_mem_wr_en = 1'b0;
    check_outs("post_init");

    host_xfer(1'b1, 1'b0, 3'd5, '0, 1'b0);
    host_xfer(1'b1, 1'b0, 3'd0, '0, 1'b0);

    // Instruction load and fetch with hold.
    host_xfer(1'b0, 1'b1, 3'd2, 10'h3A5, 1'b0);
    host_xfer(1'b0, 1'b0, 3'd2, '0, 1'b0);
    cpu_iread(3'd2);
    step();
    check_outs("ihold1");
    step();
    check_outs("ihold2");

    // Data load and read with hold.
    host_xfer(1'b1, 1'b1, 3'd1, 10'h012, 1'b0);
    host_xfer(1'b1, 1'b1, 3'd3, 10'h334, 1'b0);
    cpu_data(1'b1, 1'b0, 3'd1, '0);
    step();
    step();
    check_outs("dhold");

    // Read-before-write on the same address.
    host_xfer(1'b1, 1'b1, 3'd6, 10'h011, 1'b1);
    cpu_data(1'b1, 1'b1, 3'd6, 8'hBE);
    check("rbw_old", data_mem_data_out, 8'h11);
    cpu_data(1'b1, 1'b0, 3'd6, '0);
    check("rbw_new", data_mem_data_out, 8'hBE);

    // cpu_busy blocks the host; release accepts immediately.
    cpu_busy = 1'b1;
    host_req_valid = 1'b1; host_sel = 1'b1; host_wr = 1'b0; host_addr = 3'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("busy_ready", host_req_ready, 0);
      check("busy_no_rsp", host_rsp_valid, 0);
    end
    cpu_busy = 1'b0;
    #1;
    check("busy_release_ready", host_req_ready, 1);
    host_xfer(1'b1, 1'b0, 3'd1, '0, 1'b0);

    // A CPU strobe in the same cycle as host valid blocks ready.
    host_req_valid = 1'b1;
    instr_mem_rd_en = 1'b1;
    #1;
    check("strobe_ready", host_req_ready, 0);
    host_req_valid = 1'b0;
    instr_mem_rd_en = 1'b0;
    step();

    // Randomized mix.
    for (int i = 0; i < 80; i++) begin
      op = int'($urandom_range(0, 4));
      a  = AW'($urandom_range(0, DEPTH - 1));
      case (op)
        0: host_xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
                     DW'($urandom), 1'($urandom_range(0, 1)));
        1: cpu_iread(a);
        2: cpu_data(1'b1, 1'b0, a, '0);
        3: cpu_data(1'b0, 1'b1, a, WW'($urandom));
        default: cpu_data(1'b1, 1'b1, a, WW'($urandom));
      endcase
      if ($urandom_range(0, 3) == 0) begin
        step();
        check_outs("rand_hold");
      end
    end

    // Reset while a host response is pending.
    host_xfer(1'b1, 1'b1, 3'd3, 10'h034, 1'b0);
    host_req_valid = 1'b1; host_sel = 1'b1; host_wr = 1'b0; host_addr = 3'd3;
    #1;
    check("mid_accept", host_req_ready, 1);
    step();
    host_req_valid = 1'b0;
    rstn = 1'b0;
    step();
    check("mid_rst_rsp", host_rsp_valid, 0);
    check("mid_rst_rsp_data", host_rsp_data, 0);
    check("mid_rst_init_done", init_done, 0);
    check("mid_rst_dout", data_mem_data_out, 0);
    rstn = 1'b1;
    model_clear();
    wait_init("reinit_cycles", n);
    host_xfer(1'b1, 1'b0, 3'd3, '0, 1'b0);
    cpu_data(1'b1, 1'b0, 3'd3, '0);
    cpu_iread(3'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout no summary reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
Memory-side responder for the CPU's instruction and data memory interfaces. It holds an 8x10 instruction memory and an 8x8 data memory, answers CPU reads with a registered one-cycle latency, and commits CPU writes.
A host load/readback port with a valid/ready handshake lets the testbench or system controller program the instruction memory and inspect data memory while the CPU is idle.
After reset it clears both arrays before serving any request.

Parameters:
DATA_WIDTH, 10, instruction word width
WORD_WIDTH, 8, data memory word width
MEM_DEPTH, 8, entries per array
ADDR_WIDTH, 3, address width for both arrays and the host port

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
instr_mem_addr  in  ADDR_WIDTH  CPU instruction read address
instr_mem_rd_en  in  1  CPU instruction read strobe
instr_mem_data_out  out  DATA_WIDTH  registered instruction read data
data_mem_addr  in  ADDR_WIDTH  CPU data address
data_mem_rd_en  in  1  CPU data read strobe
data_mem_wr_en  in  1  CPU data write strobe
data_mem_data_in  in  WORD_WIDTH  CPU write data
data_mem_data_out  out  WORD_WIDTH  registered data read data
cpu_busy  in  1  high while the CPU runs a program (start accepted until done)
host_req_valid  in  1  host request valid
host_req_ready  out  1  host request accepted when valid&ready
host_sel  in  1  0 = instruction array, 1 = data array
host_wr  in  1  1 = write, 0 = read
host_addr  in  ADDR_WIDTH  host address
host_wdata  in  DATA_WIDTH  host write data; only the low WORD_WIDTH bits are used for the data array
host_rsp_valid  out  1  one-cycle response pulse
host_rsp_data  out  DATA_WIDTH  read data, or the written value echoed back; data-array values are zero-extended
init_done  out  1  high once the clear sequence has finished

Behaviour:
- Reset (rstn=0 at a clk edge):
  - all outputs go to 0, state = INIT, clear index = 0.
  - Asserting reset mid-operation aborts any pending host response (no rsp pulse) and restarts the clear sequence.
- FSM states: INIT, READY, HOST_RSP.
- INIT:
  - each cycle writes 0 to entry clear index in both arrays, then increments the index.
  - After MEM_DEPTH cycles the FSM moves to READY and init_done rises in the same edge.
  - While in INIT: CPU writes are ignored, CPU read data outputs stay 0, host_req_ready=0.
- CPU read port (READY or HOST_RSP):
  - when rd_en is high at edge N, the data output equals mem[addr] after edge N (visible in cycle N+1).
  - When rd_en is low, the output holds its last value. The CPU samples instruction data in the cycle after its fetch strobe and operand data in the cycle after its load strobe, so the hold is mandatory.
- CPU write: when data_mem_wr_en is high at edge N, data_mem[addr] takes data_mem_data_in at edge N.
- Read and write to the same data address in the same cycle: read returns the old data (read-before-write).
- The instruction array is read-only from the CPU side.
- host_req_ready = (state==READY) & ~cpu_busy & ~instr_mem_rd_en & ~data_mem_rd_en & ~data_mem_wr_en. It is combinational, so host and CPU never collide on an array.
- Host accept at edge N:
  - write commits at edge N.
  - read captures mem[host_addr] at edge N.
  - the FSM enters HOST_RSP.
- HOST_RSP: host_rsp_valid=1 for exactly one cycle with host_rsp_data valid, then the FSM returns to READY. Only one request is outstanding at a time, and ready is 0 in HOST_RSP.
- If cpu_busy rises while in HOST_RSP, the response still completes; the access has already committed.
- Address range: if MEM_DEPTH < 2^ADDR_WIDTH, addresses >= MEM_DEPTH read as 0 and writes to them are dropped, on both the CPU and host ports.
- host_rsp_data is 0 whenever host_rsp_valid=0.

Decomposition:
- Package cpu_mem_pkg:
  - width/depth constants.
  - FSM state encoding: INIT, READY, HOST_RSP.
  - host_sel encoding: SEL_INSTR=0, SEL_DATA=1.
- Sub-module cpu_mem_bank, instantiated twice (once per array):
  - one write port, one registered read port with read-hold and out-of-range masking.
  - the top level muxes the CPU, host and clear sources onto it.

Test Plan:
- Reset then idle -> init_done rises exactly 8 cycles after rstn deasserts; host read of data addr 5 returns 0x000 with rsp one cycle after accept.
- Host writes instr addr 2 = 0x3A5, then reads it back -> rsp_data 0x3A5 on both the write echo and the read; instr_mem_rd_en with addr 2 -> instr_mem_data_out 0x3A5 the next cycle and held while rd_en is low.
- Host writes data addr 1 = 0x12 and addr 3 = 0x34; CPU read strobe on addr 1 for one cycle -> data_mem_data_out 0x12 that cycle+1, still 0x12 two cycles later.
- CPU data write 0xBE to addr 6 with a simultaneous read of addr 6 (old value 0x11) -> output 0x11, then a subsequent read returns 0xBE.
- cpu_busy=1 with host_req_valid=1 -> host_req_ready stays 0, no rsp; cpu_busy falls -> accept within 1 cycle; a CPU strobe in the same cycle as host valid -> ready 0 that cycle.
- Host read accepted, rstn pulsed low in the HOST_RSP cycle -> no rsp pulse, init_done=0, data array re-cleared (addr 3 reads 0x00 after init).
